// File: rtl/uart_cmd_pkg.sv
// Shared types and opcodes for the remote command link (uart_cmd_resp).
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    PKT_WAIT_CMD = 2'd0,
    PKT_WAIT_HI  = 2'd1,
    PKT_WAIT_LO  = 2'd2
  } pkt_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOAD = 2'd1,
    TX_XMIT = 2'd2
  } tx_state_t;

  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;
  localparam logic [7:0] POS_ACK   = 8'hA5;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: RX synchronizer, mid-bit sampling down-counter, byte FSM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RX_IDLE  | line idle, waiting for a synchronized falling edge
// RX_START | counting to start-bit midpoint; a 1 there is a glitch
// RX_DATA  | sampling 8 data bits LSB first, one per BAUD_DIV cycles
// RX_STOP  | sampling stop bit; 1 -> rx_byte_vld, 0 -> framing_err
module uart_byte_rx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       framing_err,
  output logic       rx_start,
  output logic       rx_idle
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);

  logic            rx_ff1_q, rx_ff2_q, rx_prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            baud_zero;

  assign baud_zero = (baud_q == '0);
  assign rx_byte   = shift_q;
  assign rx_idle   = (state_q == RX_IDLE);

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1_q  <= 1'b1;
      rx_ff2_q  <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_ff1_q  <= RX;
      rx_ff2_q  <= rx_ff1_q;
      rx_prev_q <= rx_ff2_q;
    end
  end

  // Byte FSM state, baud down-counter, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: sample on counter terminal count, reload for the next bit.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_byte_vld = 1'b0;
    framing_err = 1'b0;
    rx_start    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_ff2_q) begin
          state_d = RX_START;
          baud_d  = BAUD_HALF;
        end
      end
      RX_START: begin
        if (baud_zero) begin
          if (rx_ff2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d  = RX_DATA;
            baud_d   = BAUD_FULL;
            bit_d    = 3'd0;
            rx_start = 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (baud_zero) begin
          shift_d = {rx_ff2_q, shift_q[7:1]};
          baud_d  = BAUD_FULL;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (baud_zero) begin
          state_d = RX_IDLE;
          if (rx_ff2_q) rx_byte_vld = 1'b1;
          else          framing_err = 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_resp.sv
// Quadcopter end of the remote command link: 3-byte command packets in,
// single-byte responses out. Optional inter-byte gap timeout: CMD_TIMEOUT_EN.
//
// state        | meaning
// -------------+--------------------------------------------------
// PKT_WAIT_CMD | next good byte is the opcode
// PKT_WAIT_HI  | next good byte is data[15:8]
// PKT_WAIT_LO  | next good byte is data[7:0], completes the packet
// TX_IDLE      | TX high, accepts send_resp
// TX_LOAD      | first cycle of start bit, counter setup
// TX_XMIT      | shifting out start/data/stop bits
module uart_cmd_resp
  import uart_cmd_pkg::*;
#(
  parameter int          BAUD_DIV    = 2604,
  parameter logic [21:0] TIMEOUT_CYC = 22'd2_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        resp_sent
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_DIV - 2);

  logic [7:0] rx_byte;
  logic       rx_byte_vld, framing_err, rx_start, rx_idle;

  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .rx_byte     (rx_byte),
    .rx_byte_vld (rx_byte_vld),
    .framing_err (framing_err),
    .rx_start    (rx_start),
    .rx_idle     (rx_idle)
  );

  pkt_state_t  pkt_q, pkt_d;
  logic [7:0]  cmd_sh_q, cmd_sh_d, hi_sh_q, hi_sh_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        gap_hit;

`ifdef CMD_TIMEOUT_EN
  logic [21:0] gap_q, gap_d;
  logic        gap_run;

  assign gap_run = (pkt_q != PKT_WAIT_CMD) && rx_idle;
  assign gap_hit = gap_run && (gap_q == '0);
  assign gap_d   = gap_run ? gap_q - 22'd1 : TIMEOUT_CYC - 22'd1;

  // Inter-byte gap down-counter, reloaded whenever it is not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= TIMEOUT_CYC - 22'd1;
    else        gap_q <= gap_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYC, rx_idle};
  assign gap_hit    = 1'b0;
`endif

  // Packet FSM register, shadow bytes and the presented command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q    <= PKT_WAIT_CMD;
      cmd_sh_q <= '0;
      hi_sh_q  <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
    end else begin
      pkt_q    <= pkt_d;
      cmd_sh_q <= cmd_sh_d;
      hi_sh_q  <= hi_sh_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
    end
  end

  // Packet assembly; completion set is evaluated last so it beats any clear.
  always_comb begin
    pkt_d    = pkt_q;
    cmd_sh_d = cmd_sh_q;
    hi_sh_d  = hi_sh_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    if (clr_cmd_rdy) rdy_d = 1'b0;
    if (rx_start && (pkt_q == PKT_WAIT_CMD)) rdy_d = 1'b0;
    if (framing_err || gap_hit) begin
      pkt_d = PKT_WAIT_CMD;
    end else if (rx_byte_vld) begin
      case (pkt_q)
        PKT_WAIT_CMD: begin
          cmd_sh_d = rx_byte;
          pkt_d    = PKT_WAIT_HI;
        end
        PKT_WAIT_HI: begin
          hi_sh_d = rx_byte;
          pkt_d   = PKT_WAIT_LO;
        end
        PKT_WAIT_LO: begin
          cmd_d  = cmd_sh_q;
          data_d = {hi_sh_q, rx_byte};
          rdy_d  = 1'b1;
          pkt_d  = PKT_WAIT_CMD;
        end
        default: pkt_d = PKT_WAIT_CMD;
      endcase
    end
  end

  assign cmd     = cmd_q;
  assign data    = data_q;
  assign cmd_rdy = rdy_q;

  tx_state_t     tx_q, tx_d;
  logic [9:0]    sh_q, sh_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    tbit_q, tbit_d;
  logic          sent_q, sent_d;

  // TX FSM register; shift register idles all-ones so TX idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= TX_IDLE;
      sh_q   <= '1;
      tcnt_q <= '0;
      tbit_q <= '0;
      sent_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      sh_q   <= sh_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      sent_q <= sent_d;
    end
  end

  // TX sequencing; LOAD is already the first cycle of the start bit.
  always_comb begin
    tx_d   = tx_q;
    sh_d   = sh_q;
    tcnt_d = tcnt_q;
    tbit_d = tbit_q;
    sent_d = sent_q;
    case (tx_q)
      TX_IDLE: begin
        if (send_resp) begin
          sh_d   = {1'b1, resp, 1'b0};
          sent_d = 1'b0;
          tx_d   = TX_LOAD;
        end
      end
      TX_LOAD: begin
        tcnt_d = BAUD_LOAD;
        tbit_d = 4'd0;
        tx_d   = TX_XMIT;
      end
      TX_XMIT: begin
        if (tcnt_q == '0) begin
          sh_d = {1'b1, sh_q[9:1]};
          if (tbit_q == 4'd9) begin
            tx_d   = TX_IDLE;
            sent_d = 1'b1;
          end else begin
            tbit_d = tbit_q + 4'd1;
            tcnt_d = BAUD_FULL;
          end
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  assign TX        = sh_q[0];
  assign resp_sent = sent_q;

endmodule

// File: tb/tb_uart_cmd_resp.sv
// Self-checking bench for uart_cmd_resp with a byte-level packet model.
module tb_uart_cmd_resp;
  import uart_cmd_pkg::*;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        resp_sent;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int          m_pos = 0;
  logic [7:0]  m_cmd_sh = 8'h00, m_hi_sh = 8'h00;
  logic [7:0]  exp_cmd = 8'h00;
  logic [15:0] exp_data = 16'h0000;
  logic        exp_rdy = 1'b0;

  uart_cmd_resp #(.BAUD_DIV(BAUD), .TIMEOUT_CYC(22'd500)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .resp        (resp),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packet rules at byte granularity.
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (m_pos == 0) exp_rdy = 1'b0;
    if (!good) begin
      m_pos = 0;
    end else if (m_pos == 0) begin
      m_cmd_sh = b; m_pos = 1;
    end else if (m_pos == 1) begin
      m_hi_sh = b; m_pos = 2;
    end else begin
      exp_cmd = m_cmd_sh; exp_data = {m_hi_sh, b}; exp_rdy = 1'b1; m_pos = 0;
    end
  endtask

  task automatic model_reset();
    m_pos = 0; exp_cmd = 8'h00; exp_data = 16'h0000; exp_rdy = 1'b0;
  endtask

  // Called and returns just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit good);
    RX = 1'b0;
    repeat (BAUD) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(posedge clk);
      #1;
    end
    RX = good;
    repeat (BAUD) @(posedge clk);
    #1;
    RX = 1'b1;
    if (!good) begin
      repeat (20) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag);
    check_val({tag, "_cmd"}, {24'd0, cmd}, {24'd0, exp_cmd});
    check_val({tag, "_data"}, {16'd0, data}, {16'd0, exp_data});
    check_val({tag, "_rdy"}, {31'd0, cmd_rdy}, {31'd0, exp_rdy});
  endtask

  task automatic send_chk(input logic [7:0] b, input bit good, input string tag);
    send_byte(b, good);
    model_byte(b, good);
    check_outs(tag);
  endtask

  // Last byte of a packet with exact cmd_rdy rise timing. The synchronized
  // edge appears 2 cycles after the drive edge, the start midpoint is
  // BAUD/2 later, the stop sample 9*BAUD after that (cycle 154), and the
  // outputs are visible the cycle after (155).
  task automatic send_timed(input logic [7:0] b, input bit clr_on_done, input string tag);
    logic pre;
    pre = exp_rdy;
    fork
      send_byte(b, 1'b1);
      begin
        repeat (2 + BAUD/2 + 9*BAUD) @(posedge clk);
        if (clr_on_done) begin
          #1 clr_cmd_rdy = 1'b1;
        end
        @(negedge clk);
        check_val({tag, "_pre"}, {31'd0, cmd_rdy}, {31'd0, pre});
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check_val({tag, "_rise"}, {31'd0, cmd_rdy}, 32'd1);
      end
    join
    model_byte(b, 1'b1);
    check_outs(tag);
  endtask

  task automatic pulse_clr(input string tag);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    check_val(tag, {31'd0, cmd_rdy}, 32'd0);
  endtask

  task automatic tx_check(input logic [7:0] r, input bit try_ignore, input string tag);
    logic [9:0] frame;
    logic       exp_tx;
    frame = {1'b1, r, 1'b0};
    send_resp = 1'b1;
    resp = r;
    for (int k = 1; k <= 170; k++) begin
      @(posedge clk);
      #1;
      send_resp = try_ignore && (k == 50);
      if (k == 50) resp = ~r;
      @(negedge clk);
      exp_tx = (k <= 160) ? frame[(k-1)/BAUD] : 1'b1;
      check_val({tag, "_tx"}, {31'd0, TX}, {31'd0, exp_tx});
      check_val({tag, "_sent"}, {31'd0, resp_sent}, (k >= 161) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    bit         good;

    repeat (2) @(posedge clk);
    #2;
    check_val("rst_tx", {31'd0, TX}, 32'd1);
    check_val("rst_sent", {31'd0, resp_sent}, 32'd0);
    check_outs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // first packet, outputs stay at reset until completion
    send_chk(SET_THRST, 1'b1, "p1b0");
    send_chk(8'h01, 1'b1, "p1b1");
    send_timed(8'h2C, 1'b0, "p1b2");
    check_val("p1_cmd_lit", {24'd0, cmd}, 32'h05);
    check_val("p1_data_lit", {16'd0, data}, 32'h012C);

    // response with an ignored second request mid-frame
    tx_check(POS_ACK, 1'b1, "ack");

    // back-to-back packets, clear coinciding with completion
    send_chk(SET_PTCH, 1'b1, "bb0");
    send_chk(8'hFF, 1'b1, "bb1");
    send_chk(8'h9C, 1'b1, "bb2");
    send_chk(SET_ROLL, 1'b1, "bb3");
    send_chk(8'h00, 1'b1, "bb4");
    send_timed(8'h64, 1'b1, "bb5");
    check_val("bb_data_lit", {16'd0, data}, 32'h0064);
    pulse_clr("clr");

    // framing error on second byte restarts packet assembly
    send_chk(8'h11, 1'b1, "fe0");
    send_chk(8'h22, 1'b0, "fe1");
    send_chk(CALIBRATE, 1'b1, "fe2");
    send_chk(8'h00, 1'b1, "fe3");
    send_chk(8'h00, 1'b1, "fe4");
    check_val("fe_cmd_lit", {24'd0, cmd}, 32'h06);

    // randomized packets, framing errors and clears; one with a parallel response
    for (int p = 0; p < 6; p++) begin
      fork
        begin
          if (p == 2) tx_check(8'($urandom), 1'b0, "dup");
        end
        begin
          for (int j = 0; j < 3; j++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            send_chk(b, good, "rnd");
            if ($urandom_range(0, 3) == 0) pulse_clr("rnd_clr");
            repeat ($urandom_range(0, 30)) @(posedge clk);
            #1;
          end
        end
      join
    end
    send_chk(8'h00, 1'b0, "align");

    // inter-byte gap
    send_chk(SET_YAW, 1'b1, "to0");
    repeat (600) @(posedge clk);
    #1;
`ifdef CMD_TIMEOUT_EN
    m_pos = 0;
`endif
    send_chk(EMER_LAND, 1'b1, "to1");
    send_chk(8'h00, 1'b1, "to2");
    send_chk(8'h00, 1'b1, "to3");
`ifdef CMD_TIMEOUT_EN
    check_val("to_cmd_lit", {24'd0, cmd}, 32'h07);
    check_val("to_data_lit", {16'd0, data}, 32'h0000);
`else
    check_val("to_cmd_lit", {24'd0, cmd}, 32'h04);
    check_val("to_data_lit", {16'd0, data}, 32'h0700);
`endif

    // asynchronous reset in the middle of TX and an RX byte
    send_resp = 1'b1;
    resp = 8'h5A;
    @(posedge clk);
    #1 send_resp = 1'b0;
    RX = 1'b0;
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("arst_tx", {31'd0, TX}, 32'd1);
    check_val("arst_sent", {31'd0, resp_sent}, 32'd0);
    check_outs("arst");
    RX = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("post_rst_tx", {31'd0, TX}, 32'd1);
    send_chk(MTRS_OFF, 1'b1, "pr0");
    send_chk(8'h00, 1'b1, "pr1");
    send_chk(8'h00, 1'b1, "pr2");
    check_val("pr_cmd_lit", {24'd0, cmd}, 32'h08);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_cmd_resp.md
Name: uart_cmd_resp

Overview:
- Quadcopter-side end of the remote command link.
- Receives 3-byte command packets over UART (cmd, data high byte, data low byte) and presents them as cmd/data with a cmd_rdy flag to the flight command FSM.
- Transmits single-byte responses (for example pos_ack 0xA5) back to the remote.
- Sits between the RX/TX pins and the command/config logic inside QuadCopter.

Parameters:
- BAUD_DIV, 2604: clk cycles per UART bit (50 MHz / 19200 baud); minimum legal value is 8.
- TIMEOUT_CYC, 22'd2_500_000: maximum inter-byte gap within a packet, in clk cycles (used only with CMD_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- RX  in  1  serial input from remote, asynchronous, idles high
- TX  out  1  serial output to remote, idles high
- cmd  out  8  opcode of last complete packet
- data  out  16  payload of last complete packet
- cmd_rdy  out  1  high when a new complete packet is held
- clr_cmd_rdy  in  1  consumer acknowledge, clears cmd_rdy
- send_resp  in  1  pulse: transmit resp
- resp  in  8  response byte, sampled on send_resp
- resp_sent  out  1  high once response transmission has finished

Behaviour:
- Reset (async, rst_n low): TX=1, cmd=8'h00, data=16'h0000, cmd_rdy=0, resp_sent=0. RX synchronizer flops reset to 1. All FSMs go to IDLE.
- UART framing is 8N1, LSB first, both directions.
- RX synchronization: 2-flop synchronizer; start is detected on a synchronized falling edge.
- RX sampling:
  - First sample at BAUD_DIV/2 after the edge (start-bit midpoint).
  - Then one sample every BAUD_DIV: 8 data bits, then the stop bit.
  - If the start bit reads 1 at its midpoint, the edge is a glitch: return to idle, no byte.
  - If the stop bit reads 0, it is a framing error: the byte is discarded and the packet FSM returns to WAIT_CMD.
- RX byte FSM: IDLE -> START -> DATA (bit counter 0..7) -> STOP -> IDLE. Emits an internal rx_byte_vld pulse for one cycle at the stop-bit sample.
- Packet FSM:
  - WAIT_CMD: a byte is latched into the cmd shadow register; go to WAIT_HI.
  - WAIT_HI: a byte is latched into the data[15:8] shadow; go to WAIT_LO.
  - WAIT_LO: the byte completes the packet; go to WAIT_CMD.
  - Packet completion: on the cycle after the WAIT_LO rx_byte_vld, cmd/data outputs load from the shadows and the low byte in the same cycle, and cmd_rdy is set.
  - cmd/data outputs change only at packet completion, never mid-packet.
- cmd_rdy:
  - Cleared by clr_cmd_rdy.
  - Also cleared when a new start bit is accepted while the packet FSM is in WAIT_CMD.
  - If clr_cmd_rdy arrives in the same cycle as packet completion, the set wins.
  - A new packet completing while cmd_rdy=1 overwrites cmd/data and keeps cmd_rdy=1.
- TX FSM: IDLE -> LOAD -> XMIT -> IDLE.
  - send_resp in IDLE latches resp into a 10-bit shift register {1, resp, 0}, clears resp_sent and moves to LOAD.
  - TX drives the start bit starting the next cycle.
  - Each bit is held for BAUD_DIV cycles; 10 bits total.
  - resp_sent is set in the cycle after the stop bit's final cycle and stays high until the next accepted send_resp.
  - send_resp while TX is busy is ignored, with no queuing.
- RX and TX are fully independent (full duplex); simultaneous activity is legal.
- Reset mid-packet or mid-byte drops partial state; TX returns high immediately.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined: a gap counter runs while the packet FSM is in WAIT_HI or WAIT_LO and the RX FSM is IDLE. When it reaches TIMEOUT_CYC, the packet FSM returns to WAIT_CMD and the partial bytes are discarded. cmd/data/cmd_rdy are unaffected.
- Undefined: there is no counter, and a partial packet waits indefinitely.

Decomposition:
- Package uart_cmd_pkg holds:
  - Enums rx_state_t, pkt_state_t, tx_state_t.
  - Localparams for the command opcodes SET_PTCH 8'h02 through MTRS_OFF 8'h08, and POS_ACK 8'hA5.
- One sub-module, uart_byte_rx: synchronizer, baud counter, byte FSM; outputs rx_byte[7:0], rx_byte_vld and framing_err.
- The packet FSM and TX remain in uart_cmd_resp.

Test Plan (BAUD_DIV=16 for sim; drive RX from a bit-banged task or from RemoteComm):
- Send bytes 05, 01, 2C -> cmd=05, data=012C, and cmd_rdy rises exactly 1 cycle after the third stop-bit sample. Outputs are unchanged from reset (00/0000) after bytes one and two.
- send_resp with resp=A5 -> TX is low for 16 cycles starting the cycle after LOAD, followed by bits 1,0,1,0,0,1,0,1 LSB first, 16 cycles each, then high. resp_sent rises at cycle 161 after send_resp. A second send_resp at cycle 50 is ignored.
- Two back-to-back packets, 02 FF 9C then 03 00 64, with no clr -> cmd_rdy stays 1 and outputs end at 03/0064. clr_cmd_rdy asserted on the completion cycle -> cmd_rdy=1.
- Framing error: second byte sent with stop bit 0, then 06 00 00 -> the next three good bytes form a packet with cmd=06, data=0000.
- With CMD_TIMEOUT_EN and TIMEOUT_CYC=500: send 04, idle 600 cycles, then send 07 00 00 -> cmd=07, data=0000. Without the macro the same stimulus gives cmd=04, data=0700.
- Assert rst_n low mid-TX and mid-RX byte -> TX=1 and all outputs at reset values asynchronously. The next full packet 08 00 00 decodes correctly.
